vgachargen_map_writer: RTL and testbench

Write-port controller for the text-mode character and colour maps (80×30 cells). It shares the maps' single write port between a host write channel (valid/ready) and an internal fill engine that paints whole row ranges with one character/colour. It issues at most one cell write per cycle and drives the `ch_map_*` / `col_map_*` write ports of the text-mode top from registers.

---
 rtl/vgachargen_map_writer.sv | 188 ++++++++++++++++++
 tb/tb_vgachargen_map_writer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vgachargen_map_writer.sv
// Write-port controller for the text-mode character/colour maps.
// Arbitrates the single map write port between a host valid/ready channel
// and a fill engine that paints whole row ranges with one char/colour.
module vgachargen_map_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = $clog2(COLS*ROWS),
  parameter int ROW_W  = $clog2(ROWS),
  parameter int CH_W   = 8,
  parameter int COL_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [CH_W-1:0]   host_char_i,
  input  logic [COL_W-1:0]  host_col_i,
  input  logic              host_char_we_i,
  input  logic              host_col_we_i,
  input  logic              fill_start_i,
  input  logic [ROW_W-1:0]  fill_row_first_i,
  input  logic [ROW_W-1:0]  fill_row_last_i,
  input  logic [CH_W-1:0]   fill_char_i,
  input  logic [COL_W-1:0]  fill_col_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] ch_map_addr_o,
  output logic [CH_W-1:0]   ch_map_data_o,
  output logic              ch_map_wen_o,
  output logic [ADDR_W-1:0] col_map_addr_o,
  output logic [COL_W-1:0]  col_map_data_o,
  output logic              col_map_wen_o
);

  localparam logic [ADDR_W:0]  CELLS  = (ADDR_W+1)'(COLS*ROWS);
  localparam logic [ROW_W:0]   ROWS_L = (ROW_W+1)'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  typedef enum logic [0:0] {S_IDLE, S_FILL} state_t;

  state_t            state_q, state_d;
  logic              fair_q, fair_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [CH_W-1:0]   fchar_q, fchar_d;
  logic [COL_W-1:0]  fcol_q, fcol_d;
  logic [ADDR_W-1:0] ch_addr_q, ch_addr_d;
  logic [CH_W-1:0]   ch_data_q, ch_data_d;
  logic              ch_wen_q, ch_wen_d;
  logic [ADDR_W-1:0] col_addr_q, col_addr_d;
  logic [COL_W-1:0]  col_data_q, col_data_d;
  logic              col_wen_q, col_wen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic host_xfer;
  logic host_bad;
  logic range_ok;

  // Host is held off for one cycle after each transfer while filling, so
  // fill and host alternate under contention.
  assign host_ready_o = (state_q == S_IDLE) | ~fair_q;
  assign host_xfer    = host_valid_i & host_ready_o;
  assign host_bad     = ({1'b0, host_addr_i} >= CELLS);
  assign range_ok     = (fill_row_first_i <= fill_row_last_i) &&
                        ({1'b0, fill_row_last_i} < ROWS_L);

  // Next-state: host write has priority, fill steps only on host-free cycles.
  always_comb begin
    state_d    = state_q;
    fair_d     = 1'b0;
    cnt_d      = cnt_q;
    end_d      = end_q;
    fchar_d    = fchar_q;
    fcol_d     = fcol_q;
    ch_addr_d  = ch_addr_q;
    ch_data_d  = ch_data_q;
    ch_wen_d   = 1'b0;
    col_addr_d = col_addr_q;
    col_data_d = col_data_q;
    col_wen_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (host_xfer) begin
      fair_d = (state_q == S_FILL);
      if (host_bad) begin
        err_d = 1'b1;
      end else begin
        if (host_char_we_i) begin
          ch_wen_d  = 1'b1;
          ch_addr_d = host_addr_i;
          ch_data_d = host_char_i;
        end
        if (host_col_we_i) begin
          col_wen_d  = 1'b1;
          col_addr_d = host_addr_i;
          col_data_d = host_col_i;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (fill_start_i) begin
          if (range_ok) begin
            fchar_d = fill_char_i;
            fcol_d  = fill_col_i;
            cnt_d   = ADDR_W'(fill_row_first_i) * COLS_A;
            end_d   = (ADDR_W'(fill_row_last_i) + ADDR_W'(1)) * COLS_A - ADDR_W'(1);
            state_d = S_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (!host_xfer) begin
          ch_wen_d   = 1'b1;
          ch_addr_d  = cnt_q;
          ch_data_d  = fchar_q;
          col_wen_d  = 1'b1;
          col_addr_d = cnt_q;
          col_data_d = fcol_q;
          cnt_d      = cnt_q + ADDR_W'(1);
          if (cnt_q == end_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FILL);
  end

  // State, fill engine and registered map-port outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      fair_q     <= 1'b0;
      cnt_q      <= '0;
      end_q      <= '0;
      fchar_q    <= '0;
      fcol_q     <= '0;
      ch_addr_q  <= '0;
      ch_data_q  <= '0;
      ch_wen_q   <= 1'b0;
      col_addr_q <= '0;
      col_data_q <= '0;
      col_wen_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fair_q     <= fair_d;
      cnt_q      <= cnt_d;
      end_q      <= end_d;
      fchar_q    <= fchar_d;
      fcol_q     <= fcol_d;
      ch_addr_q  <= ch_addr_d;
      ch_data_q  <= ch_data_d;
      ch_wen_q   <= ch_wen_d;
      col_addr_q <= col_addr_d;
      col_data_q <= col_data_d;
      col_wen_q  <= col_wen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign fill_busy_o    = busy_q;
  assign fill_done_o    = done_q;
  assign err_o          = err_q;
  assign ch_map_addr_o  = ch_addr_q;
  assign ch_map_data_o  = ch_data_q;
  assign ch_map_wen_o   = ch_wen_q;
  assign col_map_addr_o = col_addr_q;
  assign col_map_data_o = col_data_q;
  assign col_map_wen_o  = col_wen_q;

endmodule

// File: tb/tb_vgachargen_map_writer.sv
// Directed bench for vgachargen_map_writer: host writes, fills, errors,
// contention fairness and mid-fill reset.
module tb_vgachargen_map_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int ADDR_W = 12;
  localparam int ROW_W = 5;
  localparam int CH_W = 8;
  localparam int COL_W = 8;

  logic              clk;
  logic              rst_n;
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [CH_W-1:0]   host_char;
  logic [COL_W-1:0]  host_col;
  logic              host_char_we;
  logic              host_col_we;
  logic              fill_start;
  logic [ROW_W-1:0]  fill_first;
  logic [ROW_W-1:0]  fill_last;
  logic [CH_W-1:0]   fill_char;
  logic [COL_W-1:0]  fill_col;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] ch_addr;
  logic [CH_W-1:0]   ch_data;
  logic              ch_wen;
  logic [ADDR_W-1:0] col_addr;
  logic [COL_W-1:0]  col_data;
  logic              col_wen;

  int total = 0;
  int bad = 0;

  vgachargen_map_writer #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .CH_W(CH_W), .COL_W(COL_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_valid_i(host_valid), .host_ready_o(host_ready), .host_addr_i(host_addr),
    .host_char_i(host_char), .host_col_i(host_col),
    .host_char_we_i(host_char_we), .host_col_we_i(host_col_we),
    .fill_start_i(fill_start), .fill_row_first_i(fill_first), .fill_row_last_i(fill_last),
    .fill_char_i(fill_char), .fill_col_i(fill_col),
    .fill_busy_o(busy), .fill_done_o(done), .err_o(err),
    .ch_map_addr_o(ch_addr), .ch_map_data_o(ch_data), .ch_map_wen_o(ch_wen),
    .col_map_addr_o(col_addr), .col_map_data_o(col_data), .col_map_wen_o(col_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one fill with no host traffic; optionally pulse fill_start mid-fill.
  task automatic run_fill(input int first, input int last, input int inject);
    int n;
    int werr;
    int berr;
    int eerr;
    n = (last - first + 1) * COLS;
    werr = 0;
    berr = 0;
    eerr = 0;
    fill_first = first[ROW_W-1:0];
    fill_last = last[ROW_W-1:0];
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("fill_busy_start", busy, 1);
    chk("fill_no_wen_start", ch_wen, 0);
    for (int i = 0; i < n; i++) begin
      if (i == inject) begin
        fill_start = 1'b1;
        fill_first = 5'd5;
        fill_last = 5'd6;
      end
      if (busy !== 1'b1) berr++;
      if (host_ready !== 1'b1) berr++;
      tick();
      fill_start = 1'b0;
      if (ch_wen !== 1'b1 || col_wen !== 1'b1) werr++;
      if (int'(ch_addr) != first * COLS + i || int'(col_addr) != first * COLS + i) werr++;
      if (ch_data !== fill_char || col_data !== fill_col) werr++;
      if (err !== 1'b0) eerr++;
      if (i < n - 1 && done !== 1'b0) werr++;
    end
    chk("fill_writes_bad", werr, 0);
    chk("fill_busy_bad", berr, 0);
    chk("fill_err_bad", eerr, 0);
    chk("fill_done", done, 1);
    chk("fill_busy_end", busy, 0);
    tick();
    chk("fill_done_pulse", done, 0);
    chk("fill_wen_after", ch_wen, 0);
  endtask

  initial begin
    int hostcnt;
    int fillcnt;
    int consec;
    int cyc;
    int ferr;
    logic prev_host;
    logic seen_done;

    rst_n = 1'b0;
    host_valid = 1'b0;
    host_addr = '0;
    host_char = '0;
    host_col = '0;
    host_char_we = 1'b0;
    host_col_we = 1'b0;
    fill_start = 1'b0;
    fill_first = '0;
    fill_last = '0;
    fill_char = '0;
    fill_col = '0;
    #23;
    chk("rst_ch_wen", ch_wen, 0);
    chk("rst_col_wen", col_wen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", host_ready, 1);
    chk("rst_addr", ch_addr, 0);
    rst_n = 1'b1;
    tick();

    // Single host write, both maps.
    host_valid = 1'b1;
    host_addr = 12'h0A5;
    host_char = 8'h41;
    host_col = 8'h1F;
    host_char_we = 1'b1;
    host_col_we = 1'b1;
    chk("host_ready_idle", host_ready, 1);
    tick();
    host_valid = 1'b0;
    chk("host_ch_wen", ch_wen, 1);
    chk("host_col_wen", col_wen, 1);
    chk("host_ch_addr", ch_addr, 12'h0A5);
    chk("host_col_addr", col_addr, 12'h0A5);
    chk("host_ch_data", ch_data, 8'h41);
    chk("host_col_data", col_data, 8'h1F);
    tick();
    chk("host_wen_single", ch_wen, 0);
    chk("host_colwen_single", col_wen, 0);

    // Fill rows 2..3 (addresses 160..319).
    fill_char = 8'h20;
    fill_col = 8'h07;
    run_fill(2, 3, -1);

    // Invalid fill ranges.
    fill_first = 5'd5;
    fill_last = 5'd4;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("err_rev_range", err, 1);
    chk("err_rev_busy", busy, 0);
    chk("err_rev_wen", ch_wen, 0);
    tick();
    chk("err_rev_pulse", err, 0);
    chk("err_rev_busy2", busy, 0);
    fill_first = 5'd0;
    fill_last = 5'd30;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("err_row30", err, 1);
    chk("err_row30_busy", busy, 0);
    tick();
    chk("err_row30_pulse", err, 0);
    chk("err_row30_wen", ch_wen, 0);

    // Host out-of-range address.
    host_valid = 1'b1;
    host_addr = 12'd2400;
    chk("oob_ready", host_ready, 1);
    tick();
    host_valid = 1'b0;
    chk("oob_err", err, 1);
    chk("oob_ch_wen", ch_wen, 0);
    chk("oob_col_wen", col_wen, 0);
    tick();
    chk("oob_err_pulse", err, 0);

    // Host transfer with both write enables low.
    host_valid = 1'b1;
    host_addr = 12'd5;
    host_char_we = 1'b0;
    host_col_we = 1'b0;
    tick();
    host_valid = 1'b0;
    chk("nowe_ch_wen", ch_wen, 0);
    chk("nowe_col_wen", col_wen, 0);
    chk("nowe_err", err, 0);

    // fill_start during FILL is ignored; rows 1..1 complete unchanged.
    fill_char = 8'h58;
    fill_col = 8'h3C;
    run_fill(1, 1, 10);

    // Full-screen fill under continuous host pressure.
    fill_char = 8'h2E;
    fill_col = 8'h0E;
    fill_first = 5'd0;
    fill_last = 5'd29;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    host_valid = 1'b1;
    host_addr = 12'd100;
    host_char = 8'hAA;
    host_col = 8'hBB;
    host_char_we = 1'b1;
    host_col_we = 1'b1;
    hostcnt = 0;
    fillcnt = 0;
    consec = 0;
    ferr = 0;
    cyc = 0;
    prev_host = 1'b0;
    seen_done = 1'b0;
    while (cyc < 6000 && !seen_done) begin
      tick();
      cyc++;
      if (ch_wen === 1'b1 && ch_data === 8'hAA) begin
        if (ch_addr !== 12'd100 || col_wen !== 1'b1 || col_data !== 8'hBB) ferr++;
        if (prev_host) consec++;
        hostcnt++;
        prev_host = 1'b1;
      end else if (ch_wen === 1'b1 && ch_data === 8'h2E) begin
        if (int'(ch_addr) != fillcnt || col_data !== 8'h0E) ferr++;
        fillcnt++;
        prev_host = 1'b0;
      end else begin
        ferr++;
        prev_host = 1'b0;
      end
      if (done === 1'b1) seen_done = 1'b1;
    end
    host_valid = 1'b0;
    chk("contend_done_seen", seen_done, 1);
    chk("contend_fill_cnt", fillcnt, 2400);
    chk("contend_host_cnt", hostcnt, 2400);
    chk("contend_cycles", cyc, 4800);
    chk("contend_consec_host", consec, 0);
    chk("contend_data_bad", ferr, 0);
    tick();
    chk("contend_busy_end", busy, 0);

    // Reset in the middle of a fill.
    fill_char = 8'h33;
    fill_col = 8'h44;
    fill_first = 5'd10;
    fill_last = 5'd12;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (50) tick();
    chk("midrst_addr_before", ch_addr, 12'd849);
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wen", ch_wen, 0);
    chk("midrst_addr", ch_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", host_ready, 1);
    repeat (3) tick();
    chk("midrst_done_held", done, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_done_after", done, 0);
    chk("midrst_wen_after", ch_wen, 0);
    chk("midrst_busy_after", busy, 0);
    fill_char = 8'h5A;
    fill_col = 8'h12;
    run_fill(0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
